mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM-stage controller that sits on the output side of the EX/MEM pipeline register and consumes its control, address and data fields.
- Runs a req/ack handshake to a variable-latency data memory and stalls the pipeline while an access is outstanding.
- Resolves branch/jump redirects and generates the flush that feeds EX_Flush and the earlier-stage flushes.
- Presents bubble-safe writeback fields to the MEM/WB register.

Parameters:
- TIMEOUT, 255, max cycles in ACCESS before abort (MEM_TIMEOUT_EN only); counter width 8 bits, legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- RegWrite_in, MemtoReg_in  in  1 each  WB controls from EX/MEM
- Branch_in, MemRead_in, MemWrite_in, Jump_in  in  1 each  MEM controls from EX/MEM
- ALU_zero_in  in  1  branch condition
- jump_addr_in, branch_addr_in  in  32 each  redirect targets
- ALU_result_in  in  32  memory address / ALU result
- reg_read_data_2_in  in  32  store data
- EX_MEM_RegisterRd_in  in  5  destination register
- dmem_ack  in  1  memory accepted/completed access
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_req, dmem_we  out  1 each  registered request, write enable
- dmem_addr, dmem_wdata  out  32 each  registered address, write data
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- pc_sel  out  1  take redirect
- pc_target  out  32  redirect address
- flush  out  1  flush younger stages
- RegWrite_out, MemtoReg_out  out  1 each  to MEM/WB
- ALU_result_out  out  32  to MEM/WB
- mem_read_data_out  out  32  load data to MEM/WB
- MEM_WB_RegisterRd_out  out  5  to MEM/WB
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
  - state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; data hold reg=0; counter=0; mem_err=0.
  - Combinational outputs follow from these values.
  - rst mid-access drops dmem_req immediately; a late dmem_ack is ignored.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE:
    - If MemRead_in|MemWrite_in, assert mem_stall combinationally.
    - On the edge, latch dmem_addr=ALU_result_in, dmem_wdata=reg_read_data_2_in, dmem_we=MemWrite_in; set dmem_req=1; clear counter; go ACCESS.
    - If both MemRead_in and MemWrite_in are set, treat as a write.
  - ACCESS:
    - mem_stall=1; dmem_req held with stable addr/wdata/we.
    - On a sampled dmem_ack: capture dmem_rdata (loads only; stores keep the previous hold value), drop dmem_req, go DONE.
    - Ack in the first ACCESS cycle is legal.
  - DONE:
    - mem_stall=0; mem_read_data_out=hold reg.
    - The pipeline advances on this edge; next state is IDLE unconditionally, even if inputs still show a memory op.
- Minimum MEM residency of a load/store is 3 cycles: IDLE + 1 ACCESS + DONE. Back-to-back memory ops re-enter ACCESS from IDLE.
- Non-memory instruction in IDLE: mem_stall=0, single-cycle pass-through.
- Writeback outputs:
  - RegWrite_out = RegWrite_in & ~mem_stall (bubble while stalled).
  - MemtoReg_out, ALU_result_out and MEM_WB_RegisterRd_out pass through combinationally.
  - mem_read_data_out = hold reg.
- Redirect:
  - pc_sel = (Jump_in | (Branch_in & ALU_zero_in)) & ~mem_stall.
  - pc_target = Jump_in ? jump_addr_in : branch_addr_in; jump has priority.
  - flush = pc_sel.
- dmem_ack outside ACCESS is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - Counter increments each ACCESS cycle without ack.
  - When counter==TIMEOUT-1 and no ack: drop dmem_req, set hold reg=0, set mem_err=1 (sticky until rst), go DONE.
  - Ack in that same cycle wins: normal completion, no error.
- Undefined: ACCESS waits indefinitely; mem_err tied 0; no counter logic.

Test Plan:
- Load, ALU_result_in=0x100, dmem_ack 2 cycles after req with rdata=0xDEADBEEF -> dmem_addr=0x100, dmem_we=0, mem_stall high 3 cycles, mem_read_data_out=0xDEADBEEF in DONE, RegWrite_out=1 only in DONE.
- Store, addr 0x40, data 0x12345678, ack in first ACCESS cycle -> dmem_we=1, dmem_wdata=0x12345678, exactly 2 stall cycles.
- Branch_in=1, ALU_zero_in=1, branch_addr_in=0x2000, no memory op -> pc_sel=1, flush=1, pc_target=0x2000, same cycle; with ALU_zero_in=0 -> pc_sel=0.
- Jump_in=1 and Branch_in=1, zero=1, jump_addr_in=0x3000 -> pc_target=0x3000.
- rst asserted during ACCESS, then ack -> dmem_req=0 immediately, state IDLE, ack ignored, outputs at reset values.
- MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> dmem_req drops after 4 ACCESS cycles, mem_err=1, mem_read_data_out=0; mem_err stays 1 through a later successful load.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: req/ack data-memory handshake with pipeline stall, branch/jump redirect, bubble-safe WB fields.
// Optional MEM_TIMEOUT_EN: abort an access after TIMEOUT cycles without ack and raise sticky mem_err.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Jump_in,
  input  logic        ALU_zero_in,
  input  logic [31:0] jump_addr_in,
  input  logic [31:0] branch_addr_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] reg_read_data_2_in,
  input  logic [4:0]  EX_MEM_RegisterRd_in,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] mem_read_data_out,
  output logic [4:0]  MEM_WB_RegisterRd_out,
  output logic        mem_err
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_stage_ctrl: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hold_q, hold_d;
  logic        mem_op;

`ifdef MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  assign mem_op = MemRead_in | MemWrite_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          addr_d  = ALU_result_in;
          wdata_d = reg_read_data_2_in;
          we_d    = MemWrite_in;  // read+write together is a write
          req_d   = 1'b1;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          if (!we_q) hold_d = dmem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          hold_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall = (state_q == ACCESS) | ((state_q == IDLE) & mem_op);

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  // Redirect only once the instruction is free to leave MEM
  assign pc_sel    = (Jump_in | (Branch_in & ALU_zero_in)) & ~mem_stall;
  assign pc_target = Jump_in ? jump_addr_in : branch_addr_in;
  assign flush     = pc_sel;

  assign RegWrite_out          = RegWrite_in & ~mem_stall;
  assign MemtoReg_out          = MemtoReg_in;
  assign ALU_result_out        = ALU_result_in;
  assign MEM_WB_RegisterRd_out = EX_MEM_RegisterRd_in;
  assign mem_read_data_out     = hold_q;

`ifdef MEM_TIMEOUT_EN
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl; timeout scenarios run when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWrite_in = 0, MemtoReg_in = 0, Branch_in = 0, MemRead_in = 0;
  logic        MemWrite_in = 0, Jump_in = 0, ALU_zero_in = 0, dmem_ack = 0;
  logic [31:0] jump_addr_in = 0, branch_addr_in = 0, ALU_result_in = 0;
  logic [31:0] reg_read_data_2_in = 0, dmem_rdata = 0;
  logic [4:0]  EX_MEM_RegisterRd_in = 0;
  logic        dmem_req, dmem_we, mem_stall, pc_sel, flush;
  logic        RegWrite_out, MemtoReg_out, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, pc_target, ALU_result_out, mem_read_data_out;
  logic [4:0]  MEM_WB_RegisterRd_out;

  mem_stage_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Jump_in(Jump_in),
    .ALU_zero_in(ALU_zero_in), .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in),
    .ALU_result_in(ALU_result_in), .reg_read_data_2_in(reg_read_data_2_in),
    .EX_MEM_RegisterRd_in(EX_MEM_RegisterRd_in), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .mem_stall(mem_stall), .pc_sel(pc_sel), .pc_target(pc_target), .flush(flush),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .ALU_result_out(ALU_result_out),
    .mem_read_data_out(mem_read_data_out), .MEM_WB_RegisterRd_out(MEM_WB_RegisterRd_out),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stalls;
    logic [31:0] rdata;
    logic        err;
  } sb_item_t;

  sb_item_t    sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] hold_m = '0;
  logic        err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one load/store from IDLE; ack_delay = ACCESS cycle carrying the ack (0 = never).
  task automatic do_mem(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int ack_delay, input bit tmo);
    sb_item_t it;
    int k;
    it.stalls = tmo ? TMO + 1 : ack_delay + 1;
    it.rdata  = tmo ? 32'h0 : (wr ? hold_m : rdata);
    it.err    = err_m | tmo;
    sb.push_back(it);
    hold_m = it.rdata;
    err_m  = it.err;

    MemRead_in = rd; MemWrite_in = wr; ALU_result_in = addr; reg_read_data_2_in = wdata;
    RegWrite_in = !wr; MemtoReg_in = !wr; Branch_in = 1; ALU_zero_in = 1; Jump_in = 0;
    branch_addr_in = 32'h0000_2000; dmem_rdata = rdata; dmem_ack = 0;
    #1;
    k = 0;
    while (mem_stall && k < 300) begin
      if (k == 0) begin
        chk("stall_regwrite_bubble", {31'b0, RegWrite_out}, 32'd0);
        chk("stall_no_redirect", {31'b0, pc_sel}, 32'd0);
      end
      if (k == 1) begin
        chk("access_req", {31'b0, dmem_req}, 32'd1);
        chk("access_addr", dmem_addr, addr);
        chk("access_we", {31'b0, dmem_we}, {31'b0, wr});
        chk("access_wdata", dmem_wdata, wdata);
      end
      dmem_ack = (ack_delay != 0) && (k == ack_delay);
      @(posedge clk); #1;
      k++;
    end
    dmem_ack = 0;
    #1;
    it = sb.pop_front();
    chk("done_stall_cycles", k, it.stalls);
    chk("done_rdata", mem_read_data_out, it.rdata);
    chk("done_mem_err", {31'b0, mem_err}, {31'b0, it.err});
    chk("done_req_low", {31'b0, dmem_req}, 32'd0);
    chk("done_regwrite", {31'b0, RegWrite_out}, {31'b0, !wr});
    chk("done_redirect", {31'b0, pc_sel}, 32'd1);
    // Inputs still show the op: DONE must fall back to IDLE, not restart
    @(posedge clk); #1;
    chk("post_done_req_low", {31'b0, dmem_req}, 32'd0);
  endtask

  task automatic clear_ops();
    MemRead_in = 0; MemWrite_in = 0; Branch_in = 0; Jump_in = 0; ALU_zero_in = 0;
    RegWrite_in = 0; MemtoReg_in = 0; dmem_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_rdata", mem_read_data_out, 32'd0);
    chk("rst_err", {31'b0, mem_err}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    do_mem(1, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 0);
    do_mem(0, 1, 32'h40, 32'h1234_5678, 32'hBAD0_BAD0, 1, 0);
    do_mem(1, 1, 32'h44, 32'hA5A5_A5A5, 32'hBAD1_BAD1, 1, 0);
    do_mem(1, 0, 32'h80, 32'h0, 32'h0BAD_F00D, 20, 0);

    clear_ops();
    RegWrite_in = 1; MemtoReg_in = 1; ALU_result_in = 32'h55; EX_MEM_RegisterRd_in = 5'd7;
    Branch_in = 1; ALU_zero_in = 1; branch_addr_in = 32'h2000; jump_addr_in = 32'h3000;
    #1;
    chk("br_pc_sel", {31'b0, pc_sel}, 32'd1);
    chk("br_flush", {31'b0, flush}, 32'd1);
    chk("br_target", pc_target, 32'h2000);
    chk("br_no_stall", {31'b0, mem_stall}, 32'd0);
    chk("pass_regwrite", {31'b0, RegWrite_out}, 32'd1);
    chk("pass_memtoreg", {31'b0, MemtoReg_out}, 32'd1);
    chk("pass_alu", ALU_result_out, 32'h55);
    chk("pass_rd", {27'b0, MEM_WB_RegisterRd_out}, 32'd7);
    ALU_zero_in = 0; #1;
    chk("br_nt_pc_sel", {31'b0, pc_sel}, 32'd0);
    chk("br_nt_flush", {31'b0, flush}, 32'd0);
    Jump_in = 1; ALU_zero_in = 1; #1;
    chk("jmp_prio_target", pc_target, 32'h3000);
    chk("jmp_prio_sel", {31'b0, pc_sel}, 32'd1);
    Branch_in = 0; ALU_zero_in = 0; #1;
    chk("jmp_only_sel", {31'b0, pc_sel}, 32'd1);
    clear_ops();
    @(posedge clk); #1;

    // Reset in the middle of an access; a late ack must be ignored
    MemRead_in = 1; ALU_result_in = 32'h200;
    @(posedge clk); #1;
    chk("rstmid_req_before", {31'b0, dmem_req}, 32'd1);
    #2 rst = 1;
    #1;
    chk("rstmid_req", {31'b0, dmem_req}, 32'd0);
    chk("rstmid_addr", dmem_addr, 32'd0);
    chk("rstmid_rdata", mem_read_data_out, 32'd0);
    hold_m = '0; err_m = 1'b0;
    dmem_ack = 1; dmem_rdata = 32'hFFFF_0000; MemRead_in = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("rstmid_ack_ignored_req", {31'b0, dmem_req}, 32'd0);
    chk("rstmid_ack_ignored_stall", {31'b0, mem_stall}, 32'd0);
    chk("rstmid_ack_ignored_rdata", mem_read_data_out, 32'd0);
    dmem_ack = 0;
    @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
    do_mem(1, 0, 32'h300, 32'h0, 32'h1111_2222, TMO, 0);
    do_mem(1, 0, 32'h304, 32'h0, 32'h3333_4444, 0, 1);
    do_mem(1, 0, 32'h308, 32'h0, 32'h5555_6666, 2, 0);
`else
    do_mem(1, 0, 32'h300, 32'h0, 32'h1111_2222, 2, 0);
`endif
    clear_ops();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
